// File: rtl/rlwe_wport_arbiter.sv
// Round-robin arbiter for the shared 30-bit coefficient-memory write port.
// Locked bursts keep ownership; an idle owner is revoked after MAX_IDLE cycles.
module rlwe_wport_arbiter #(
    parameter int DATA_W   = 30,
    parameter int ADDR_W   = 9,
    parameter int MAX_IDLE = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [3:0]            lock,
    input  logic [4*ADDR_W-1:0]   addr_in,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic                  we_out,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [DATA_W-1:0]     data_out,
    output logic                  owner_valid,
    output logic                  err_timeout
);

    typedef enum logic {FREE, OWN} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  owner_reg, owner_next;
    logic [1:0]  ptr_reg, ptr_next;
    logic [7:0]  idle_reg, idle_next;
    logic        timeout_next;
    logic        any_gnt;
    logic [1:0]  gnt_idx;
    logic [1:0]  scan_idx;

    logic [ADDR_W-1:0] addr_arr [4];
    logic [DATA_W-1:0] data_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi] = addr_in[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Grant depends only on state, pointer and requests; never on addr/data.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        any_gnt  = 1'b0;
        scan_idx = '0;
        if (state_reg == OWN) begin
            gnt_idx = owner_reg;
            any_gnt = req[owner_reg];
        end else begin
            // Scan from the far end so the candidate closest to ptr wins last.
            for (int k = 3; k >= 0; k--) begin
                scan_idx = ptr_reg + 2'(k);
                if (req[scan_idx]) begin
                    gnt_idx = scan_idx;
                    any_gnt = 1'b1;
                end
            end
        end
        gnt[gnt_idx] = any_gnt;
        if (!rst_n) begin
            gnt = '0;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        idle_next    = idle_reg;
        timeout_next = 1'b0;
        if (any_gnt) begin
            idle_next = '0;
            if (lock[gnt_idx]) begin
                state_next = OWN;
                owner_next = gnt_idx;
            end else begin
                state_next = FREE;
                ptr_next   = gnt_idx + 2'd1;
            end
        end else if (state_reg == OWN) begin
            if (idle_reg + 8'd1 == 8'(MAX_IDLE)) begin
                state_next   = FREE;
                ptr_next     = owner_reg + 2'd1;
                idle_next    = '0;
                timeout_next = 1'b1;
            end else begin
                idle_next = idle_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FREE;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            idle_reg    <= '0;
            sel         <= '0;
            we_out      <= 1'b0;
            addr_out    <= '0;
            data_out    <= '0;
            owner_valid <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            idle_reg    <= idle_next;
            owner_valid <= (state_next == OWN);
            err_timeout <= timeout_next;
            we_out      <= any_gnt;
            // Hold select/address/data when idle to keep the write mux quiet.
            if (any_gnt) begin
                sel      <= gnt_idx;
                addr_out <= addr_arr[gnt_idx];
                data_out <= data_arr[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_rlwe_wport_arbiter.sv
// Bench for rlwe_wport_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural arbitration model.
module tb_rlwe_wport_arbiter;

    localparam int DATA_W   = 30;
    localparam int ADDR_W   = 9;
    localparam int MAX_IDLE = 15;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req, lock;
    logic [4*ADDR_W-1:0] addr_in;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                we_out;
    logic [ADDR_W-1:0]   addr_out;
    logic [DATA_W-1:0]   data_out;
    logic                owner_valid;
    logic                err_timeout;

    always #5 clk = ~clk;

    rlwe_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_IDLE(MAX_IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .addr_in(addr_in), .data_in(data_in), .gnt(gnt), .sel(sel),
        .we_out(we_out), .addr_out(addr_out), .data_out(data_out),
        .owner_valid(owner_valid), .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: free/owned flag, owner, round-robin start and idle counter as plain ints.
    bit m_free  = 1'b1;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_idle  = 0;
    logic              e_we, e_ov, e_to;
    logic [1:0]        e_sel;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [3:0]        obs_gnt;
    int                to_seen, we_seen, burst_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_free = 1'b1; m_owner = 0; m_ptr = 0; m_idle = 0;
        e_we = 1'b0; e_ov = 1'b0; e_to = 1'b0;
        e_sel = '0; e_addr = '0; e_data = '0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt"},  64'(gnt), 64'd0);
        chk({tag, "_sel"},  64'(sel), 64'd0);
        chk({tag, "_we"},   64'(we_out), 64'd0);
        chk({tag, "_addr"}, 64'(addr_out), 64'd0);
        chk({tag, "_data"}, 64'(data_out), 64'd0);
        chk({tag, "_own"},  64'(owner_valid), 64'd0);
        chk({tag, "_to"},   64'(err_timeout), 64'd0);
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < 4; i++) begin
            addr_in[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
            data_in[i*DATA_W +: DATA_W] = DATA_W'($urandom());
        end
    endtask

    // One clock of traffic with the currently driven inputs.
    task automatic cycle();
        int g;
        g = -1;
        if (m_free) begin
            for (int k = 0; k < 4; k++)
                if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end else if (req[m_owner]) begin
            g = m_owner;
        end
        @(negedge clk);
        obs_gnt = gnt;
        chk("gnt", 64'(gnt), (g >= 0) ? (64'd1 << g) : 64'd0);
        e_to = 1'b0;
        if (g >= 0) begin
            e_we   = 1'b1;
            e_sel  = 2'(g);
            e_addr = addr_in[g*ADDR_W +: ADDR_W];
            e_data = data_in[g*DATA_W +: DATA_W];
            if (lock[g]) begin
                m_free = 1'b0; m_owner = g; m_idle = 0;
            end else begin
                m_free = 1'b1; m_ptr = (g + 1) % 4;
            end
        end else begin
            e_we = 1'b0;
            if (!m_free) begin
                m_idle++;
                if (m_idle == MAX_IDLE) begin
                    m_free = 1'b1; m_ptr = (m_owner + 1) % 4; m_idle = 0; e_to = 1'b1;
                end
            end
        end
        e_ov = !m_free;
        @(posedge clk);
        #1;
        $display("cyc req=%b lock=%b gnt=%b we=%b sel=%0d addr=%h data=%h own=%b to=%b",
                 req, lock, obs_gnt, we_out, sel, addr_out, data_out, owner_valid, err_timeout);
        chk("we_out", 64'(we_out), 64'(e_we));
        chk("sel", 64'(sel), 64'(e_sel));
        chk("addr_out", 64'(addr_out), 64'(e_addr));
        chk("data_out", 64'(data_out), 64'(e_data));
        chk("owner_valid", 64'(owner_valid), 64'(e_ov));
        chk("err_timeout", 64'(err_timeout), 64'(e_to));
        to_seen += int'(err_timeout);
        we_seen += int'(we_out);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; lock = '0; addr_in = '0; data_in = '0;
        model_reset();
        #3;
        reset_checks("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full contention, no locks: strict rotation.
        req = 4'b1111; lock = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            randomize_fields();
            cycle();
        end

        // Single requester 2 with known fields.
        randomize_fields();
        req = 4'b0100;
        addr_in[2*ADDR_W +: ADDR_W] = 9'h1A5;
        data_in[2*DATA_W +: DATA_W] = 30'h2AAAAAAA;
        cycle();
        chk("single_gnt", 64'(obs_gnt), 64'h4);
        chk("single_addr", 64'(addr_out), 64'h1A5);
        chk("single_data", 64'(data_out), 64'h2AAAAAAA);
        chk("single_sel", 64'(sel), 64'd2);

        // Move the pointer to 1, then a locked burst from requester 1 against requester 0.
        req = 4'b0001; lock = 4'b0000;
        cycle();
        req = 4'b0011;
        burst_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            lock = (b < 3) ? 4'b0010 : 4'b0000;
            randomize_fields();
            cycle();
            burst_cnt += int'(obs_gnt[1]);
        end
        chk("burst_len", 64'(burst_cnt), 64'd4);
        lock = 4'b0000;
        cycle();
        chk("after_burst_gnt", 64'(obs_gnt), 64'h1);

        // Requester 3 locks then goes quiet; requester 0 waits for the timeout.
        req = 4'b1000; lock = 4'b1000;
        cycle();
        to_seen = 0; we_seen = 0;
        req = 4'b0001; lock = 4'b0000;
        repeat (MAX_IDLE) cycle();
        chk("idle_we_count", 64'(we_seen), 64'd0);
        chk("timeout_pulses", 64'(to_seen), 64'd1);
        cycle();
        chk("post_timeout_gnt", 64'(obs_gnt), 64'h1);
        chk("timeout_single", 64'(to_seen), 64'd1);

        // Reset in the middle of an OWN(1) burst.
        req = 4'b0010; lock = 4'b0010;
        cycle();
        cycle();
        rst_n = 1'b0;
        #2;
        reset_checks("midrst");
        @(posedge clk);
        #1;
        reset_checks("midrst_hold");
        rst_n = 1'b1;
        model_reset();
        req = 4'b1111; lock = 4'b0000;
        cycle();
        chk("post_reset_gnt", 64'(obs_gnt), 64'h1);

        // Quiet bus: outputs hold, no writes.
        req = 4'b0000;
        repeat (3) begin
            randomize_fields();
            cycle();
        end
        chk("quiet_we", 64'(we_out), 64'd0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            randomize_fields();
            req  = 4'($urandom());
            lock = 4'($urandom()) & 4'($urandom());
            if ($urandom_range(0, 7) == 0) req = 4'b0000;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
